dmux_stream: RTL and testbench

Registered, flow-controlled demultiplexer that routes a `WIDTH`-bit word from one input stream to one of `CHANNELS` output streams, or to all of them at once. Each output channel has its own one-entry holding slot with valid/ready backpressure. It is the parametrised, sequential successor to the fixed 1-bit, 8-way combinational demux. It sits between a single producer (for example, the CPU write path) and several independent consumers.

---
 rtl/dmux_pkg.sv | 23 ++
 rtl/dmux_slot.sv | 78 +++++++
 rtl/dmux_stream.sv | 82 ++++++++
 tb/tb_dmux_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmux_pkg
//  Description : Shared types and helpers for the dmux_stream demultiplexer.
//                - slot_state_t : occupancy state of one output holding slot
//                - sel_w()      : channel-select width for a channel count
//  Revision    : 1.0  initial release
// ============================================================================
package dmux_pkg;

    // Occupancy of a single one-entry output slot.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Number of select bits needed to address 'channels' outputs.
    function automatic int sel_w(input int channels);
        return $clog2(channels);
    endfunction

endpackage : dmux_pkg
`default_nettype wire

// File: rtl/dmux_slot.sv
`default_nettype none
// ============================================================================
//  Module      : dmux_slot
//  Description : One-entry holding register for one output channel of the
//                stream demultiplexer.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous active-low reset (empties the slot)
//                load   - write din into the slot this cycle
//                drain  - consumer takes the held word this cycle
//                din    - word to store on load
//                dout   - currently held word
//                valid  - slot is FULL
//  Revision    : 1.0  initial release
// ============================================================================
module dmux_slot
    import dmux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_data;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data register: only a load ever changes the stored word, so the word
    // stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end
    end

    // Next-state logic. A load while FULL is only ever issued together with a
    // drain (the top gates it), so load wins and the slot stays FULL with the
    // new word -- back-to-back streaming without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (load) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (drain && !load) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    assign valid = (r_state == FULL);
    assign dout  = r_data;

endmodule : dmux_slot
`default_nettype wire

// File: rtl/dmux_stream.sv
`default_nettype none
// ============================================================================
//  Module      : dmux_stream
//  Description : Registered, flow-controlled 1-to-CHANNELS demultiplexer.
//                A word is routed to the slot named by in_sel, or to every
//                slot when in_bcast is set. Each output has its own one-entry
//                slot with valid/ready handshake; latency is one cycle.
//  Ports       : clk       - clock, rising edge
//                rst_n     - synchronous active-low reset
//                in_data   - word to route
//                in_sel    - target channel for a unicast
//                in_bcast  - deliver to all channels (in_sel ignored)
//                in_valid  - producer offers a word
//                in_ready  - word is accepted this cycle
//                out_data  - per-channel held word
//                out_valid - per-channel slot full
//                out_ready - per-channel consumer takes the word
//  Revision    : 1.0  initial release
// ============================================================================
module dmux_stream
    import dmux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = sel_w(CHANNELS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic [SEL_W-1:0]                 in_sel,
    input  logic                             in_bcast,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [CHANNELS-1:0][WIDTH-1:0]   out_data,
    output logic [CHANNELS-1:0]              out_valid,
    input  logic [CHANNELS-1:0]              out_ready
);

    logic [CHANNELS-1:0] w_can_accept;
    logic [CHANNELS-1:0] w_load;
    logic [CHANNELS-1:0] w_drain;
    logic                w_xfer;

    // A slot can take a new word if it is empty or is being emptied this cycle.
    assign w_can_accept = ~out_valid | out_ready;

    // Broadcast is all-or-nothing: it waits until every slot can accept.
    // in_ready does not look at in_valid or in_data; it is forced low in reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (in_bcast) begin
                in_ready = &w_can_accept;
            end else begin
                in_ready = w_can_accept[in_sel];
            end
        end
    end

    assign w_xfer = in_valid && in_ready;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
            assign w_load[g]  = w_xfer && (in_bcast || (in_sel == SEL_W'(g)));
            assign w_drain[g] = out_valid[g] && out_ready[g];

            dmux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (w_load[g]),
                .drain (w_drain[g]),
                .din   (in_data),
                .dout  (out_data[g]),
                .valid (out_valid[g])
            );
        end
    endgenerate

endmodule : dmux_stream
`default_nettype wire

// File: tb/tb_dmux_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmux_stream
//  Description : Self-checking bench for dmux_stream (WIDTH=16, CHANNELS=8).
//                Directed scenarios followed by randomized traffic, all
//                compared against a behavioural slot-array model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmux_stream;

    localparam int C_WIDTH = 16;
    localparam int C_CH    = 8;

    logic                         clk;
    logic                         rst_n;
    logic [C_WIDTH-1:0]           in_data;
    logic [2:0]                   in_sel;
    logic                         in_bcast;
    logic                         in_valid;
    logic                         in_ready;
    logic [C_CH-1:0][C_WIDTH-1:0] out_data;
    logic [C_CH-1:0]              out_valid;
    logic [C_CH-1:0]              out_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: one valid flag and one word per channel.
    bit               m_valid [C_CH];
    logic [C_WIDTH-1:0] m_data [C_CH];
    logic             obs_ready;

    dmux_stream #(
        .WIDTH    (C_WIDTH),
        .CHANNELS (C_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [C_CH-1:0] model_valid_vec();
        logic [C_CH-1:0] v;
        for (int i = 0; i < C_CH; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [127:0] model_data_vec();
        logic [C_CH-1:0][C_WIDTH-1:0] d;
        for (int i = 0; i < C_CH; i++) d[i] = m_data[i];
        return 128'(d);
    endfunction

    // Acceptance rule: a slot accepts when empty or being drained; a broadcast
    // needs every slot; nothing is accepted during reset.
    function automatic logic model_ready();
        logic all_ok;
        if (!rst_n) return 1'b0;
        all_ok = 1'b1;
        for (int i = 0; i < C_CH; i++)
            if (m_valid[i] && !out_ready[i]) all_ok = 1'b0;
        if (in_bcast) return all_ok;
        return !m_valid[int'(in_sel)] || out_ready[int'(in_sel)];
    endfunction

    // Called right after inputs are driven (1 time unit past a rising edge).
    // Checks in_ready, advances the model across the next edge, checks outputs.
    task automatic step();
        logic               exp_rdy;
        logic               xfer;
        bit                 nv [C_CH];
        logic [C_WIDTH-1:0] nd [C_CH];
        #2;
        exp_rdy   = model_ready();
        obs_ready = in_ready;
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        xfer = in_valid && exp_rdy;
        for (int i = 0; i < C_CH; i++) begin
            nv[i] = m_valid[i];
            nd[i] = m_data[i];
            if (!rst_n) begin
                nv[i] = 1'b0;
                nd[i] = '0;
            end else if (xfer && (in_bcast || int'(in_sel) == i)) begin
                nv[i] = 1'b1;
                nd[i] = in_data;
            end else if (m_valid[i] && out_ready[i]) begin
                nv[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < C_CH; i++) begin
            m_valid[i] = nv[i];
            m_data[i]  = nd[i];
        end
        check("out_valid", 128'(out_valid), 128'(model_valid_vec()));
        check("out_data", 128'(out_data), model_data_vec());
    endtask

    task automatic drive(input logic v, input logic b, input logic [2:0] s,
                         input logic [C_WIDTH-1:0] d, input logic [C_CH-1:0] r);
        in_valid  = v;
        in_bcast  = b;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        for (int i = 0; i < C_CH; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
        end
        obs_ready = 1'b0;

        // Reset held for 3 cycles with a word on offer.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 3'd2, 16'h1234, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_in_ready", 128'(obs_ready), 128'd0);
        end
        check("rst_out_valid", 128'(out_valid), 128'h00);
        check("rst_out_data", 128'(out_data), 128'd0);

        // Unicast to channel 5.
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 3'd5, 16'hBEEF, 8'h00);
        step();
        check("uni_valid", 128'(out_valid), 128'h20);
        check("uni_data5", 128'(out_data[5]), 128'hBEEF);

        // Backpressure isolation around a stalled channel 2.
        drive(1'b1, 1'b0, 3'd2, 16'h0B0B, 8'h00);
        step();
        drive(1'b1, 1'b0, 3'd2, 16'h1111, 8'h00);
        step();
        check("bp_held_ready", 128'(obs_ready), 128'd0);
        check("bp_held_data2", 128'(out_data[2]), 128'h0B0B);
        drive(1'b1, 1'b0, 3'd3, 16'h2222, 8'h00);
        step();
        check("bp_other_ready", 128'(obs_ready), 128'd1);
        check("bp_other_data3", 128'(out_data[3]), 128'h2222);
        drive(1'b1, 1'b0, 3'd2, 16'h1111, 8'h04);
        step();
        check("bp_release_data2", 128'(out_data[2]), 128'h1111);
        check("bp_release_valid2", 128'(out_valid[2]), 128'd1);

        // Simultaneous drain and load on channel 0: no bubble.
        drive(1'b1, 1'b0, 3'd0, 16'hAAAA, 8'h00);
        step();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b0, 3'd0, 16'(k), 8'h01);
            step();
            check("stream_valid0", 128'(out_valid[0]), 128'd1);
            check("stream_data0", 128'(out_data[0]), 128'(k));
        end

        // Broadcast blocked by a stalled channel 7, then released.
        drive(1'b1, 1'b0, 3'd7, 16'h7777, 8'h00);
        step();
        drive(1'b1, 1'b1, 3'd1, 16'h5A5A, 8'h7F);
        step();
        check("bc_blocked_ready", 128'(obs_ready), 128'd0);
        check("bc_blocked_data7", 128'(out_data[7]), 128'h7777);
        drive(1'b1, 1'b1, 3'd1, 16'h5A5A, 8'hFF);
        step();
        check("bc_valid", 128'(out_valid), 128'hFF);
        check("bc_data", 128'(out_data), {8{16'h5A5A}});

        // Reset in the middle of activity.
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 8'hFF);
        in_valid = 1'b0;
        step();
        drive(1'b1, 1'b0, 3'd1, 16'h1010, 8'h00);
        step();
        drive(1'b1, 1'b0, 3'd4, 16'h4040, 8'h00);
        step();
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 128'(out_valid), 128'h00);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 3'd1, 16'hC0DE, 8'h00);
        step();
        check("post_rst_valid", 128'(out_valid), 128'h02);
        check("post_rst_data1", 128'(out_data[1]), 128'hC0DE);

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_bcast  = ($urandom_range(0, 7) == 0);
            in_sel    = 3'($urandom_range(0, 7));
            in_data   = 16'($urandom);
            out_ready = 8'($urandom) | 8'($urandom);
            if (k % 40 < 10) out_ready = 8'($urandom) & 8'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule : tb_dmux_stream
`default_nettype wire
